// File: rtl/switch_egress_arbiter_if.sv
// Egress arbiter bus: port FIFO pop side and
// the shared egress valid/ready link.
interface switch_egress_arbiter_if #(
  parameter int NUM_OF_PORTS = 4,
  parameter int WORD_WIDTH   = 8
);
  localparam int PW = $clog2(NUM_OF_PORTS);

  logic [NUM_OF_PORTS-1:0] port_ready;
  logic [WORD_WIDTH-1:0]   port_out [NUM_OF_PORTS];
  logic [NUM_OF_PORTS-1:0] port_read;
  logic [WORD_WIDTH-1:0]   egr_data;
  logic                    egr_valid;
  logic                    egr_ready;
  logic [PW-1:0]           grant_id;
  logic                    busy;

  modport master (
    input  port_ready,
    input  port_out,
    input  egr_ready,
    output port_read,
    output egr_data,
    output egr_valid,
    output grant_id,
    output busy
  );

  modport slave (
    output port_ready,
    output port_out,
    output egr_ready,
    input  port_read,
    input  egr_data,
    input  egr_valid,
    input  grant_id,
    input  busy
  );
endinterface

// File: rtl/switch_egress_arbiter.sv
// Round-robin egress scheduler: pops port FIFOs
// one word at a time into a registered egress stage.
module switch_egress_arbiter #(
  parameter int NUM_OF_PORTS = 4,
  parameter int WORD_WIDTH   = 8,
  parameter int MAX_BURST    = 4
) (
  input logic clk,
  input logic rst_n,
  switch_egress_arbiter_if.master bus
);
  localparam int PW = $clog2(NUM_OF_PORTS);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE, ISSUE, CAPTURE, DRAIN
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [PW-1:0]         grant_id;
  logic [PW-1:0]         last_grant;
  logic [PW-1:0]         pick;
  logic [PW:0]           sum;
  logic [BW-1:0]         burst_cnt;
  logic [WORD_WIDTH-1:0] egr_data;
  logic                  egr_valid;
  logic                  any_req;
  logic                  found;
  logic                  hs;
  logic                  more;

  assign any_req = |bus.port_ready;
  assign hs      = egr_valid & bus.egr_ready;
  assign more    = (burst_cnt < BW'(MAX_BURST))
                 & bus.port_ready[grant_id];

  // Round-robin search starting after the last grant
  always_comb begin
    pick  = '0;
    found = 1'b0;
    sum   = '0;
    for (int i = 1; i <= NUM_OF_PORTS; i++) begin
      sum = {1'b0, last_grant} + (PW+1)'(i);
      if (sum >= (PW+1)'(NUM_OF_PORTS))
        sum = sum - (PW+1)'(NUM_OF_PORTS);
      if (!found && bus.port_ready[sum[PW-1:0]]) begin
        found = 1'b1;
        pick  = sum[PW-1:0];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = DRAIN;
      DRAIN:   if (hs) state_nxt = more ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant, burst count and egress register updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id   <= '0;
      last_grant <= PW'(NUM_OF_PORTS - 1);
      burst_cnt  <= '0;
      egr_data   <= '0;
      egr_valid  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (any_req) begin
          grant_id  <= pick;
          burst_cnt <= '0;
        end
        CAPTURE: begin
          egr_data  <= bus.port_out[grant_id];
          egr_valid <= 1'b1;
          burst_cnt <= burst_cnt + 1'b1;
        end
        DRAIN: if (hs) begin
          egr_valid <= 1'b0;
          if (!more) last_grant <= grant_id;
        end
        default: ;
      endcase
    end
  end

  // Pop strobe decoded from flops only
  always_comb begin
    bus.port_read = '0;
    if (state == ISSUE)
      bus.port_read[grant_id] = 1'b1;
    bus.busy = (state != IDLE);
  end

  assign bus.egr_data  = egr_data;
  assign bus.egr_valid = egr_valid;
  assign bus.grant_id  = grant_id;
endmodule

// File: tb/tb_switch_egress_arbiter.sv
// Directed bench for switch_egress_arbiter with
// a small FIFO model per port and an egress monitor.
module tb_switch_egress_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  switch_egress_arbiter_if #(
    .NUM_OF_PORTS(4), .WORD_WIDTH(8)
  ) bus ();

  switch_egress_arbiter #(
    .NUM_OF_PORTS(4), .WORD_WIDTH(8), .MAX_BURST(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [4][64];
  int head [4];
  int tail [4];

  initial for (int p = 0; p < 4; p++) begin
    head[p] = 0;
    tail[p] = 0;
  end

  always_comb
    for (int p = 0; p < 4; p++)
      bus.port_ready[p] = (head[p] != tail[p]);

  always @(posedge clk)
    for (int p = 0; p < 4; p++)
      if (bus.port_read[p]) begin
        bus.port_out[p] <= mem[p][head[p] % 64];
        head[p] <= head[p] + 1;
      end

  logic [7:0] rx_data [64];
  logic [1:0] rx_grant [64];
  int nrx = 0;
  int pops = 0;
  int onehot_err = 0;

  always @(posedge clk)
    if (rst_n) begin
      if (bus.egr_valid && bus.egr_ready && nrx < 64) begin
        rx_data[nrx] = bus.egr_data;
        rx_grant[nrx] = bus.grant_id;
        nrx = nrx + 1;
      end
      if ($countones(bus.port_read) > 1) onehot_err = onehot_err + 1;
      if (bus.port_read != 4'b0) pops = pops + 1;
    end

  task automatic push(input int p, input logic [7:0] d);
    mem[p][tail[p] % 64] = d;
    tail[p] = tail[p] + 1;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 200 && bus.busy; c++) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.egr_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.egr_valid !== 1'b0 || bus.egr_data !== 8'h00 ||
        bus.port_read !== 4'b0 || bus.busy !== 1'b0 ||
        bus.grant_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_values: valid=%b data=%h read=%b busy=%b gid=%0d, required 0 0 0000 0 0",
               bus.egr_valid, bus.egr_data, bus.port_read, bus.busy, bus.grant_id);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fairness();
    logic [7:0] exp;
    int g;
    nrx = 0;
    pops = 0;
    onehot_err = 0;
    bus.egr_ready = 1'b1;
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < 8; k++) push(p, 8'(p * 16 + k));
    for (int c = 0; c < 2000 && nrx < 32; c++) @(negedge clk);
    wait_idle();
    checks++;
    if (nrx !== 32) begin
      errors++;
      $display("FAIL fair_count: got %0d words, required 32", nrx);
    end
    for (int i = 0; i < 32 && i < nrx; i++) begin
      g = (i / 4) % 4;
      exp = 8'(g * 16 + (i / 16) * 4 + i % 4);
      checks++;
      if (rx_data[i] !== exp || rx_grant[i] !== 2'(g)) begin
        errors++;
        $display("FAIL fair_word%0d: data=%h gid=%0d, required %h %0d",
                 i, rx_data[i], rx_grant[i], exp, g);
      end
    end
    checks++;
    if (pops !== 32 || onehot_err !== 0) begin
      errors++;
      $display("FAIL fair_pops: pops=%0d onehot_err=%0d, required 32 0",
               pops, onehot_err);
    end
  endtask

  task automatic test_single_port();
    logic ev, eb;
    logic [3:0] er;
    logic [7:0] ed;
    bus.egr_ready = 1'b1;
    push(2, 8'hA1);
    push(2, 8'hA2);
    push(2, 8'hA3);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      ev = (k == 2 || k == 5 || k == 8);
      er = (k % 3 == 0 && k < 9) ? 4'b0100 : 4'b0000;
      eb = (k < 9);
      ed = 8'(8'hA1 + k / 3);
      checks++;
      if (bus.egr_valid !== ev || bus.port_read !== er ||
          bus.busy !== eb || (ev && bus.egr_data !== ed)) begin
        errors++;
        $display("FAIL single_cyc%0d: valid=%b read=%b busy=%b data=%h, required %b %b %b %h",
                 k, bus.egr_valid, bus.port_read, bus.busy, bus.egr_data,
                 ev, er, eb, ed);
      end
    end
  endtask

  task automatic test_back_pressure();
    bus.egr_ready = 1'b0;
    push(1, 8'h51);
    push(1, 8'h52);
    for (int c = 0; c < 20 && !bus.egr_valid; c++) @(negedge clk);
    checks++;
    if (bus.egr_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_first_valid: valid=%b, required 1", bus.egr_valid);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (bus.egr_valid !== 1'b1 || bus.egr_data !== 8'h51 ||
          bus.port_read !== 4'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b data=%h read=%b, required 1 51 0000",
                 k, bus.egr_valid, bus.egr_data, bus.port_read);
      end
    end
    bus.egr_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.port_read !== 4'b0010 || bus.egr_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_resume: read=%b valid=%b, required 0010 0",
               bus.port_read, bus.egr_valid);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (bus.egr_valid !== 1'b1 || bus.egr_data !== 8'h52) begin
      errors++;
      $display("FAIL bp_second: valid=%b data=%h, required 1 52",
               bus.egr_valid, bus.egr_data);
    end
    wait_idle();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_idle: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_rr_wrap();
    bus.egr_ready = 1'b1;
    push(3, 8'h31);
    @(negedge clk);
    wait_idle();
    nrx = 0;
    push(0, 8'h01);
    push(3, 8'h33);
    for (int c = 0; c < 100 && nrx < 2; c++) @(negedge clk);
    wait_idle();
    checks++;
    if (nrx !== 2 || rx_grant[0] !== 2'd0 || rx_data[0] !== 8'h01 ||
        rx_grant[1] !== 2'd3 || rx_data[1] !== 8'h33) begin
      errors++;
      $display("FAIL rr_wrap: n=%0d g0=%0d d0=%h g1=%0d d1=%h, required 2 0 01 3 33",
               nrx, rx_grant[0], rx_data[0], rx_grant[1], rx_data[1]);
    end
  endtask

  task automatic test_early_drain();
    logic [1:0] eg [5];
    logic [7:0] ed [5];
    eg = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
    ed = '{8'h11, 8'h12, 8'h21, 8'h22, 8'h23};
    bus.egr_ready = 1'b1;
    nrx = 0;
    push(1, 8'h11);
    push(1, 8'h12);
    push(2, 8'h21);
    push(2, 8'h22);
    push(2, 8'h23);
    for (int c = 0; c < 200 && nrx < 5; c++) @(negedge clk);
    wait_idle();
    checks++;
    if (nrx !== 5) begin
      errors++;
      $display("FAIL drain_count: got %0d, required 5", nrx);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rx_grant[i] !== eg[i] || rx_data[i] !== ed[i]) begin
        errors++;
        $display("FAIL drain_word%0d: gid=%0d data=%h, required %0d %h",
                 i, rx_grant[i], rx_data[i], eg[i], ed[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.egr_ready = 1'b0;
    push(2, 8'h77);
    for (int c = 0; c < 20 && !bus.egr_valid; c++) @(negedge clk);
    checks++;
    if (bus.egr_valid !== 1'b1 || bus.grant_id !== 2'd2) begin
      errors++;
      $display("FAIL rst_pre: valid=%b gid=%0d, required 1 2",
               bus.egr_valid, bus.grant_id);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.egr_valid !== 1'b0 || bus.egr_data !== 8'h00 ||
        bus.port_read !== 4'b0 || bus.busy !== 1'b0 ||
        bus.grant_id !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid_drain: valid=%b data=%h read=%b busy=%b gid=%0d, required 0 0 0000 0 0",
               bus.egr_valid, bus.egr_data, bus.port_read, bus.busy, bus.grant_id);
    end
    for (int p = 0; p < 4; p++) tail[p] = head[p];
    @(negedge clk);
    rst_n = 1'b1;
    nrx = 0;
    bus.egr_ready = 1'b1;
    for (int p = 0; p < 4; p++) push(p, 8'(p * 16 + 12));
    for (int c = 0; c < 200 && nrx < 4; c++) @(negedge clk);
    wait_idle();
    checks++;
    if (nrx !== 4 || rx_grant[0] !== 2'd0 || rx_data[0] !== 8'h0C ||
        rx_grant[3] !== 2'd3 || rx_data[3] !== 8'h3C) begin
      errors++;
      $display("FAIL rst_first_grant: n=%0d g0=%0d d0=%h g3=%0d d3=%h, required 4 0 0c 3 3c",
               nrx, rx_grant[0], rx_data[0], rx_grant[3], rx_data[3]);
    end
    push(3, 8'h3F);
    @(negedge clk);
    checks++;
    if (bus.port_read !== 4'b1000) begin
      errors++;
      $display("FAIL rst_pre_issue: read=%b, required 1000", bus.port_read);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.port_read !== 4'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_issue: read=%b busy=%b, required 0000 0",
               bus.port_read, bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single_port();
    test_back_pressure();
    test_rr_wrap();
    test_early_drain();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
